// File: rtl/spart_pkg.sv
// Shared definitions for the SPART CPU-side bus interface.
//   ADDR_*      : ioaddr decode values
//   STAT_*      : bit positions within the status word (read of ADDR_STAT)
//   CTRL_*      : bit positions within the control word (write of ADDR_STAT)
//   tx_state_t  : transmit launcher states
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DIVL = 2'b10;
    localparam logic [1:0] ADDR_DIVH = 2'b11;

    localparam int STAT_RDA     = 0;
    localparam int STAT_TXNF    = 1;
    localparam int STAT_RXOVR   = 2;
    localparam int STAT_TXOVF   = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    localparam int CTRL_RX_FLUSH = 0;
    localparam int CTRL_TX_FLUSH = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO used for both the RX and TX character queues.
//   push_i/data_i : enqueue; accepted when not full, or when full with a pop
//   pop_i         : dequeue; ignored when empty
//   flush_i       : empties the FIFO on this edge, discarding any push/pop
//   full_o/empty_o/count_o : occupancy, derived from a registered count
//   head_o        : oldest entry (undefined content when empty)
module spart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [W-1:0]           head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push needs, so full + pop still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spart_bus_fifo.sv
// CPU-side bus interface for the SPART with RX/TX FIFOs.
//   iocs/iorw/ioaddr/databus : processor port; databus driven only on reads
//   rx_done/rx_shift_reg     : completed character from spart_rx
//   tbr                      : spart_tx idle/ready
//   transmit_buffer/tx_begin : character and one-cycle launch to spart_tx
//   rda                      : RX FIFO non-empty
//   divisor_buffer           : {high, low} baud divisor
module spart_bus_fifo
    import spart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iocs,
    input  logic                  iorw,
    input  logic [1:0]            ioaddr,
    inout  wire  [DATA_W-1:0]     databus,
    input  logic                  rx_done,
    input  logic [DATA_W+1:0]     rx_shift_reg,
    input  logic                  tbr,
    output logic [DATA_W-1:0]     transmit_buffer,
    output logic                  tx_begin,
    output logic                  rda,
    output logic [2*DATA_W-1:0]   divisor_buffer
);
    localparam int RXCW = $clog2(RX_DEPTH) + 1;
    localparam int TXCW = $clog2(TX_DEPTH) + 1;

    logic              rd_acc, wr_acc, ctrl_wr, stat_rd;
    logic              rx_pop, rx_flush, rx_full, rx_empty;
    logic              tx_wr, tx_push, tx_flush, tx_full, tx_empty, launch;
    logic [RXCW-1:0]   rx_count;
    logic [TXCW-1:0]   tx_count_unused;
    logic [DATA_W-1:0] rx_head, tx_head, rd_data;
    logic [DATA_W-1:0] divl_q, divh_q;
    logic              rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
    logic              rx_ovr_set, tx_ovf_set;
    tx_state_t         state_q;
    logic              unused_frame;

    assign unused_frame = ^{rx_shift_reg[DATA_W+1], rx_shift_reg[0]};

    assign rd_acc   = iocs && iorw;
    assign wr_acc   = iocs && !iorw;
    assign rx_pop   = rd_acc && (ioaddr == ADDR_DATA);
    assign stat_rd  = rd_acc && (ioaddr == ADDR_STAT);
    assign ctrl_wr  = wr_acc && (ioaddr == ADDR_STAT);
    assign tx_wr    = wr_acc && (ioaddr == ADDR_DATA);
    assign rx_flush = ctrl_wr && databus[CTRL_RX_FLUSH];
    assign tx_flush = ctrl_wr && databus[CTRL_TX_FLUSH];

    // A full TX FIFO drops the write outright, even if the launcher pops this cycle.
    assign tx_push    = tx_wr && !tx_full;
    assign tx_ovf_set = tx_wr && tx_full;
    // RX overrun only when no real pop frees a slot; a flushed push is not an overrun.
    assign rx_ovr_set = rx_done && rx_full && !(rx_pop && !rx_empty) && !rx_flush;
    assign launch     = (state_q == TX_IDLE) && tbr && !tx_empty;

    spart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_done),
        .data_i  (rx_shift_reg[DATA_W:1]),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count),
        .head_o  (rx_head)
    );

    spart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .data_i  (databus),
        .pop_i   (launch),
        .flush_i (tx_flush),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count_unused),
        .head_o  (tx_head)
    );

    // rda decodes the FIFO's registered count, so it only moves on a clock edge.
    assign rda            = !rx_empty;
    assign divisor_buffer = {divh_q, divl_q};

    // Set beats the read-clear in the same cycle.
    assign rx_ovr_d = rx_ovr_set || (rx_ovr_q && !stat_rd);
    assign tx_ovf_d = tx_ovf_set || (tx_ovf_q && !stat_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovr_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            divl_q   <= '0;
            divh_q   <= '0;
        end else begin
            rx_ovr_q <= rx_ovr_d;
            tx_ovf_q <= tx_ovf_d;
            if (wr_acc && ioaddr == ADDR_DIVL) divl_q <= databus;
            if (wr_acc && ioaddr == ADDR_DIVH) divh_q <= databus;
        end
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            ADDR_DATA: rd_data = rx_empty ? '0 : rx_head;
            ADDR_STAT: begin
                rd_data[STAT_RDA]   = !rx_empty;
                rd_data[STAT_TXNF]  = !tx_full;
                rd_data[STAT_RXOVR] = rx_ovr_q;
                rd_data[STAT_TXOVF] = tx_ovf_q;
                rd_data[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(rx_count);
            end
            ADDR_DIVL: rd_data = divl_q;
            default:   rd_data = divh_q;
        endcase
    end

    assign databus = rd_acc ? rd_data : {DATA_W{1'bz}};

    // Launcher: tx_begin is high exactly while in TX_START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= TX_IDLE;
            tx_begin        <= 1'b0;
            transmit_buffer <= '0;
        end else begin
            tx_begin <= 1'b0;
            case (state_q)
                TX_IDLE: if (launch) begin
                    state_q         <= TX_START;
                    transmit_buffer <= tx_head;
                    tx_begin        <= 1'b1;
                end
                TX_START:     state_q <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (!tbr) state_q <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (tbr)  state_q <= TX_IDLE;
                default:      state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_fifo.sv
module tb_spart_bus_fifo;
    import spart_pkg::*;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_RX = 2;

    typedef struct {
        int         kind;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic        clk, rst, iocs, iorw, rx_done;
    logic [1:0]  ioaddr;
    logic [9:0]  rx_shift_reg;
    logic        drv_en;
    logic [7:0]  drv_val;
    wire  [7:0]  databus;
    logic        tbr_model, tbr_hold_low;
    wire         tbr;
    logic [7:0]  transmit_buffer;
    logic        tx_begin, rda;
    logic [15:0] divisor_buffer;

    int n_pass, n_chk;
    vec_t tbl[$];

    assign databus = drv_en ? drv_val : 8'hzz;
    assign tbr     = tbr_model & ~tbr_hold_low;

    spart_bus_fifo #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .iocs            (iocs),
        .iorw            (iorw),
        .ioaddr          (ioaddr),
        .databus         (databus),
        .rx_done         (rx_done),
        .rx_shift_reg    (rx_shift_reg),
        .tbr             (tbr),
        .transmit_buffer (transmit_buffer),
        .tx_begin        (tx_begin),
        .rda             (rda),
        .divisor_buffer  (divisor_buffer)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // spart_tx model: goes busy one cycle after a launch, ready again 20 cycles later.
    initial begin
        tbr_model = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_begin) begin
                @(negedge clk);
                tbr_model = 1'b0;
                repeat (20) @(negedge clk);
                tbr_model = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_val = d;
        @(negedge clk);
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] d);
        rx_done = 1'b1; rx_shift_reg = {1'b1, d, 1'b0};
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    function automatic vec_t v(input int k, input logic [1:0] a, input logic [7:0] d,
                               input logic [7:0] e);
        vec_t r;
        r.kind = k; r.addr = a; r.data = d; r.exp = e;
        return r;
    endfunction

    initial begin
        logic [7:0] rd;
        logic [7:0] bufs [2];
        int         w [2];
        int         np, cnt;
        logic       prev, found;

        n_pass = 0; n_chk = 0;
        rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rx_done = 1'b0; rx_shift_reg = '0; drv_en = 1'b0; drv_val = '0;
        tbr_hold_low = 1'b0;

        // Divisor, RX ordering and RX overrun as {op, addr, data, expected read}.
        tbl.push_back(v(K_WR, ADDR_DIVL, 8'h45, 8'h00));
        tbl.push_back(v(K_WR, ADDR_DIVH, 8'h01, 8'h00));
        tbl.push_back(v(K_RD, ADDR_DIVL, 8'h00, 8'h45));
        tbl.push_back(v(K_RD, ADDR_DIVH, 8'h00, 8'h01));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'hA1, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'hB2, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'hC3, 8'h00));
        tbl.push_back(v(K_RD, ADDR_STAT, 8'h00, 8'h33));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'hA1));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'hB2));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'hC3));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h00));
        tbl.push_back(v(K_RD, ADDR_STAT, 8'h00, 8'h02));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'h11, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'h22, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'h33, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'h44, 8'h00));
        tbl.push_back(v(K_RX, ADDR_DATA, 8'h55, 8'h00));
        tbl.push_back(v(K_RD, ADDR_STAT, 8'h00, 8'h47));
        tbl.push_back(v(K_RD, ADDR_STAT, 8'h00, 8'h43));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h11));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h22));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h33));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h44));
        tbl.push_back(v(K_RD, ADDR_DATA, 8'h00, 8'h00));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_begin", 32'(tx_begin), 32'd0);
        chk("rst_rda", 32'(rda), 32'd0);
        chk("rst_divisor", 32'(divisor_buffer), 32'h0);
        chk("rst_txbuf", 32'(transmit_buffer), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_WR: do_write(tbl[i].addr, tbl[i].data);
                K_RX: do_rx(tbl[i].data);
                default: begin
                    do_read(tbl[i].addr, rd);
                    chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(tbl[i].exp));
                end
            endcase
        end
        chk("divisor_buffer", 32'(divisor_buffer), 32'h0145);
        chk("rda_after_drain", 32'(rda), 32'd0);

        // Bus released when not selected: the bench's own 0 must read back unchanged.
        iorw = 1'b1; ioaddr = ADDR_DIVL; drv_en = 1'b1; drv_val = 8'h00;
        #1 chk("databus_released", 32'(databus), 32'h0);
        drv_en = 1'b0;
        @(negedge clk);

        // rda rises on the edge that accepts rx_done
        rx_done = 1'b1; rx_shift_reg = {1'b1, 8'h5A, 1'b0};
        #1 chk("rda_before_edge", 32'(rda), 32'd0);
        @(negedge clk);
        rx_done = 1'b0;
        chk("rda_after_edge", 32'(rda), 32'd1);
        do_read(ADDR_DATA, rd);
        chk("rda_data", 32'(rd), 32'h5A);

        // Full RX FIFO: rx_done together with a data read is not an overrun
        do_rx(8'h01); do_rx(8'h02); do_rx(8'h03); do_rx(8'h04);
        rx_done = 1'b1; rx_shift_reg = {1'b1, 8'h99, 1'b0};
        iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_DATA;
        #1 rd = databus;
        @(negedge clk);
        rx_done = 1'b0; iocs = 1'b0;
        chk("full_pop_head", 32'(rd), 32'h01);
        do_read(ADDR_STAT, rd);
        chk("full_pop_status", 32'(rd), 32'h43);
        do_read(ADDR_DATA, rd); chk("full_pop_rd2", 32'(rd), 32'h02);
        do_read(ADDR_DATA, rd); chk("full_pop_rd3", 32'(rd), 32'h03);
        do_read(ADDR_DATA, rd); chk("full_pop_rd4", 32'(rd), 32'h04);
        do_read(ADDR_DATA, rd); chk("full_pop_rd5", 32'(rd), 32'h99);

        // TX drain, including launch latency and a push/pop in the same cycle
        do_write(ADDR_DATA, 8'h55);
        chk("tx_lat_early", 32'(tx_begin), 32'd0);
        do_write(ADDR_DATA, 8'h66);
        chk("tx_lat_begin", 32'(tx_begin), 32'd1);
        np = 0; prev = 1'b0; w[0] = 0; w[1] = 0; bufs[0] = '0; bufs[1] = '0;
        for (int c = 0; c < 60; c++) begin
            if (tx_begin) begin
                if (!prev) begin
                    np++;
                    if (np <= 2) bufs[np-1] = transmit_buffer;
                end
                if (np >= 1 && np <= 2) w[np-1]++;
            end
            prev = tx_begin;
            @(negedge clk);
        end
        chk("tx_pulses", 32'(np), 32'd2);
        chk("tx_char0", 32'(bufs[0]), 32'h55);
        chk("tx_char1", 32'(bufs[1]), 32'h66);
        chk("tx_width0", 32'(w[0]), 32'd1);
        chk("tx_width1", 32'(w[1]), 32'd1);

        // TX overflow and flush with the transmitter held busy
        tbr_hold_low = 1'b1;
        do_write(ADDR_DATA, 8'hA0); do_write(ADDR_DATA, 8'hA1); do_write(ADDR_DATA, 8'hA2);
        do_write(ADDR_DATA, 8'hA3); do_write(ADDR_DATA, 8'hA4);
        do_read(ADDR_STAT, rd);
        chk("tx_ovf_status", 32'(rd), 32'h08);
        do_write(ADDR_STAT, 8'h02);
        do_read(ADDR_STAT, rd);
        chk("tx_flush_status", 32'(rd), 32'h02);
        tbr_hold_low = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_begin) cnt++;
        end
        chk("tx_flush_no_launch", 32'(cnt), 32'd0);

        // Reset while waiting for spart_tx to finish
        do_write(ADDR_DATA, 8'h77);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (tx_begin) found = 1'b1;
            else @(negedge clk);
        end
        chk("wd_launch_seen", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wd_rst_tx_begin", 32'(tx_begin), 32'd0);
        chk("wd_rst_txbuf", 32'(transmit_buffer), 32'h0);
        chk("wd_rst_divisor", 32'(divisor_buffer), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_write(ADDR_DATA, 8'h88);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (tx_begin) found = 1'b1;
            else @(negedge clk);
        end
        chk("wd_relaunch_seen", 32'(found), 32'd1);
        chk("wd_relaunch_char", 32'(transmit_buffer), 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
